// File: rtl/vga_timing_pkg.sv
// ============================================================================
// vga_timing_pkg : default 800x600@60 timing, derived constants, shared types
// Rev 1.0
// ============================================================================
`default_nettype none

package vga_timing_pkg;

  localparam int VGA_H_SYNC = 128;
  localparam int VGA_H_BP   = 88;
  localparam int VGA_H_ACT  = 800;
  localparam int VGA_H_FP   = 40;
  localparam int VGA_V_SYNC = 4;
  localparam int VGA_V_BP   = 23;
  localparam int VGA_V_ACT  = 600;
  localparam int VGA_V_FP   = 1;

  localparam int VGA_H_TOTAL     = VGA_H_SYNC + VGA_H_BP + VGA_H_ACT + VGA_H_FP;
  localparam int VGA_V_TOTAL     = VGA_V_SYNC + VGA_V_BP + VGA_V_ACT + VGA_V_FP;
  localparam int VGA_H_ACT_START = VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_ACT_START = VGA_V_SYNC + VGA_V_BP;

  localparam int NUM_BARS  = 8;
  localparam int BAR_IDX_W = $clog2(NUM_BARS);

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic hit;
  } vid_ctl_t;

  // First x of bar k: smallest x with x*NUM_BARS/h_act >= k
  function automatic int bar_start(input int k, input int h_act);
    return (k * h_act + NUM_BARS - 1) / NUM_BARS;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_window_timing_delay_line.sv
// ============================================================================
// vga_delay_line : DEPTH-stage register pipe with per-bit reset value
// Rev 1.0
// ============================================================================
`default_nettype none

module vga_delay_line #(
  parameter int               WIDTH   = 4,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CLK_40M,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  always_ff @(posedge CLK_40M or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= RST_VAL;
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/vga_window_timing.sv
// ============================================================================
// vga_window_timing : VGA timing with a frame-buffer-fed image window.
// Optional TEST_PATTERN_EN adds tp_on and 8 vertical colour bars. Rev 1.0
// ============================================================================
`default_nettype none

module vga_window_timing
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int H_ACT    = VGA_H_ACT,
  parameter int H_FP     = VGA_H_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int V_ACT    = VGA_V_ACT,
  parameter int V_FP     = VGA_V_FP,
  parameter int SYNC_POL = 1,
  parameter int PIX_W    = 8,
  parameter int WIN_W    = 128,
  parameter int WIN_H    = 96,
  parameter int ADDR_W   = 16,
  parameter int RD_LAT   = 1,
  parameter int BG_COLOR = 0
) (
  input  logic              CLK_40M,
  input  logic              RST_N,
  input  logic [10:0]       win_x,
  input  logic [9:0]        win_y,
`ifdef TEST_PATTERN_EN
  input  logic              tp_on,
`endif
  input  logic [PIX_W-1:0]  pix_in,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              HSYNC,
  output logic              VSYNC,
  output logic              DE,
  output logic [PIX_W-1:0]  DATA_OUT,
  output logic              frame_start
);

  localparam int H_TOTAL     = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL     = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int H_ACT_START = H_SYNC + H_BP;
  localparam int V_ACT_START = V_SYNC + V_BP;
  localparam int H_ACT_END   = H_ACT_START + H_ACT;
  localparam int V_ACT_END   = V_ACT_START + V_ACT;
  localparam int HC_W        = $clog2(H_TOTAL);
  localparam int VC_W        = $clog2(V_TOTAL);
  localparam int CW          = 16;
  localparam int DLY         = RD_LAT + 1;

  localparam logic             SYNC_ON = (SYNC_POL != 0);
  localparam logic [PIX_W-1:0] BG_PIX  = PIX_W'(BG_COLOR);
  localparam vid_ctl_t         CTL_RST = '{hsync: ~SYNC_ON, vsync: ~SYNC_ON, de: 1'b0, hit: 1'b0};

  logic [HC_W-1:0]   r_h_cnt;
  logic [VC_W-1:0]   r_v_cnt;
  logic [10:0]       r_win_x;
  logic [9:0]        r_win_y;
  logic [ADDR_W-1:0] r_row_base;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_frame_start;

  logic              w_h_last;
  logic              w_v_last;
  logic              w_frame_pos;
  logic [CW-1:0]     w_hc;
  logic [CW-1:0]     w_vc;
  logic [CW-1:0]     w_x;
  logic [CW-1:0]     w_y;
  logic [CW-1:0]     w_wx;
  logic [CW-1:0]     w_wy;
  logic              w_h_act;
  logic              w_v_act;
  logic              w_active;
  logic              w_in_x;
  logic              w_in_y;
  logic              w_tp;
  logic              w_hit;
  logic              w_row_adv;
  logic [ADDR_W-1:0] w_addr;
  vid_ctl_t          w_ctl;
  vid_ctl_t          w_ctl_d;
  logic [PIX_W-1:0]  w_bar_pix;

  // Free-running raster counters
  assign w_h_last = (r_h_cnt == HC_W'(H_TOTAL - 1));
  assign w_v_last = (r_v_cnt == VC_W'(V_TOTAL - 1));

  always_ff @(posedge CLK_40M or negedge RST_N) begin
    if (!RST_N) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  assign w_frame_pos = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign w_hc        = CW'(r_h_cnt);
  assign w_vc        = CW'(r_v_cnt);
  assign w_x         = w_hc - CW'(H_ACT_START);
  assign w_y         = w_vc - CW'(V_ACT_START);
  assign w_wx        = CW'(r_win_x);
  assign w_wy        = CW'(r_win_y);

  assign w_h_act  = (w_hc >= CW'(H_ACT_START)) && (w_hc < CW'(H_ACT_END));
  assign w_v_act  = (w_vc >= CW'(V_ACT_START)) && (w_vc < CW'(V_ACT_END));
  assign w_active = w_h_act && w_v_act;
  assign w_in_x   = (w_x >= w_wx) && (w_x < w_wx + CW'(WIN_W));
  assign w_in_y   = (w_y >= w_wy) && (w_y < w_wy + CW'(WIN_H));
  assign w_hit    = w_active && w_in_x && w_in_y && !w_tp;

  // Row base steps by WIN_W per window line, so clipped columns still consume addresses
  assign w_row_adv = w_h_last && w_v_act && w_in_y;
  assign w_addr    = r_row_base + ADDR_W'(w_x - w_wx);

  always_ff @(posedge CLK_40M or negedge RST_N) begin
    if (!RST_N) begin
      r_row_base <= '0;
    end else if (w_frame_pos) begin
      r_row_base <= '0;
    end else if (w_row_adv) begin
      r_row_base <= r_row_base + ADDR_W'(WIN_W);
    end
  end

  always_ff @(posedge CLK_40M or negedge RST_N) begin
    if (!RST_N) begin
      r_rd_en       <= 1'b0;
      r_rd_addr     <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_rd_en       <= w_hit;
      r_rd_addr     <= w_hit ? w_addr : '0;
      r_frame_start <= w_frame_pos;
    end
  end

  // Window position is only picked up once per frame
  always_ff @(posedge CLK_40M or negedge RST_N) begin
    if (!RST_N) begin
      r_win_x <= '0;
      r_win_y <= '0;
    end else if (r_frame_start) begin
      r_win_x <= win_x;
      r_win_y <= win_y;
    end
  end

  assign w_ctl.hsync = (w_hc < CW'(H_SYNC)) ? SYNC_ON : ~SYNC_ON;
  assign w_ctl.vsync = (w_vc < CW'(V_SYNC)) ? SYNC_ON : ~SYNC_ON;
  assign w_ctl.de    = w_active;
  assign w_ctl.hit   = w_hit;

  vga_delay_line #(
    .WIDTH   ($bits(vid_ctl_t)),
    .DEPTH   (DLY),
    .RST_VAL (CTL_RST)
  ) u_ctl_dly (
    .CLK_40M (CLK_40M),
    .RST_N   (RST_N),
    .i_d     (w_ctl),
    .o_q     (w_ctl_d)
  );

`ifdef TEST_PATTERN_EN
  logic                 r_tp_on;
  logic [BAR_IDX_W-1:0] w_bar;
  logic [BAR_IDX_W-1:0] w_bar_d;

  always_ff @(posedge CLK_40M or negedge RST_N) begin
    if (!RST_N) begin
      r_tp_on <= 1'b0;
    end else if (r_frame_start) begin
      r_tp_on <= tp_on;
    end
  end

  assign w_tp = r_tp_on;

  // Bar index by threshold compare; thresholds are elaboration-time constants
  always_comb begin
    w_bar = '0;
    for (int k = 1; k < NUM_BARS; k++) begin
      if (w_x >= CW'(bar_start(k, H_ACT))) w_bar = BAR_IDX_W'(k);
    end
  end

  vga_delay_line #(
    .WIDTH   (BAR_IDX_W),
    .DEPTH   (DLY),
    .RST_VAL ('0)
  ) u_bar_dly (
    .CLK_40M (CLK_40M),
    .RST_N   (RST_N),
    .i_d     (w_bar),
    .o_q     (w_bar_d)
  );

  // Replicate the bar index MSB-first across the pixel width
  always_comb begin
    w_bar_pix = '0;
    for (int i = 0; i < PIX_W; i++) begin
      w_bar_pix[PIX_W-1-i] = w_bar_d[BAR_IDX_W-1-(i % BAR_IDX_W)];
    end
  end
`else
  assign w_tp      = 1'b0;
  assign w_bar_pix = '0;
`endif

  always_comb begin
    DATA_OUT = '0;
    if (w_ctl_d.hit) begin
      DATA_OUT = pix_in;
    end else if (w_ctl_d.de) begin
      DATA_OUT = w_tp ? w_bar_pix : BG_PIX;
    end
  end

  assign HSYNC       = w_ctl_d.hsync;
  assign VSYNC       = w_ctl_d.vsync;
  assign DE          = w_ctl_d.de;
  assign rd_en       = r_rd_en;
  assign rd_addr     = r_rd_addr;
  assign frame_start = r_frame_start;

endmodule

`default_nettype wire

// File: tb/tb_vga_window_timing.sv
// Directed bench: small raster (44x26), RD_LAT=1 and RD_LAT=3 instances fed by
// address-echo RAM models, checked against a per-pixel reference.
`timescale 1ns/1ps

module tb_vga_window_timing;

  localparam int HT    = 44;
  localparam int VT    = 26;
  localparam int FRAME = HT * VT;
  localparam int WW    = 8;
  localparam int WH    = 4;
  localparam int BG    = 165;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [10:0] win_x;
  logic [9:0]  win_y;
  logic        tp_on;

  logic [7:0] pix1, pix3, p3a, p3b;
  logic       rd_en1, rd_en3, hs1, hs3, vs1, vs3, de1, de3, fs1, fs3;
  logic [5:0] rd_addr1, rd_addr3;
  logic [7:0] data1, data3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vga_window_timing #(
    .H_SYNC(4), .H_BP(4), .H_ACT(32), .H_FP(4),
    .V_SYNC(2), .V_BP(2), .V_ACT(20), .V_FP(2),
    .SYNC_POL(1), .PIX_W(8), .WIN_W(WW), .WIN_H(WH),
    .ADDR_W(6), .RD_LAT(1), .BG_COLOR(BG)
  ) u_dut1 (
    .CLK_40M(clk), .RST_N(rst_n), .win_x(win_x), .win_y(win_y),
`ifdef TEST_PATTERN_EN
    .tp_on(tp_on),
`endif
    .pix_in(pix1), .rd_en(rd_en1), .rd_addr(rd_addr1), .HSYNC(hs1),
    .VSYNC(vs1), .DE(de1), .DATA_OUT(data1), .frame_start(fs1)
  );

  vga_window_timing #(
    .H_SYNC(4), .H_BP(4), .H_ACT(32), .H_FP(4),
    .V_SYNC(2), .V_BP(2), .V_ACT(20), .V_FP(2),
    .SYNC_POL(1), .PIX_W(8), .WIN_W(WW), .WIN_H(WH),
    .ADDR_W(6), .RD_LAT(3), .BG_COLOR(BG)
  ) u_dut3 (
    .CLK_40M(clk), .RST_N(rst_n), .win_x(win_x), .win_y(win_y),
`ifdef TEST_PATTERN_EN
    .tp_on(tp_on),
`endif
    .pix_in(pix3), .rd_en(rd_en3), .rd_addr(rd_addr3), .HSYNC(hs3),
    .VSYNC(vs3), .DE(de3), .DATA_OUT(data3), .frame_start(fs3)
  );

  // RAM models return the address as data after RD_LAT clocks
  always @(posedge clk) begin
    pix1 <= 8'(rd_addr1);
    p3a  <= 8'(rd_addr3);
    p3b  <= p3a;
    pix3 <= p3b;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference for output index idx: {HSYNC, VSYNC, DE, DATA_OUT}
  function automatic logic [10:0] model(input int idx, input int wx, input int wy, input bit tp);
    int h, v, x, y, b;
    logic hs, vs, de;
    logic [7:0] d;
    h  = idx % HT;
    v  = idx / HT;
    hs = (h < 4);
    vs = (v < 2);
    de = (h >= 8) && (h < 40) && (v >= 4) && (v < 24);
    x  = h - 8;
    y  = v - 4;
    d  = 8'd0;
    if (de) begin
      if (tp) begin
        b = x * 8 / 32;
        d = {b[2:0], b[2:0], b[2:1]};
      end else if (x >= wx && x < wx + WW && y >= wy && y < wy + WH) begin
        d = 8'((y - wy) * WW + (x - wx));
      end else begin
        d = 8'(BG);
      end
    end
    return {hs, vs, de, d};
  endfunction

  // Runs one output frame (index 0 = counter (0,0) at RD_LAT=1 pins)
  task automatic run_frame(input string name, input int wx, input int wy, input bit tp,
                           input int exp_rd, input int pa_idx, input int pa_exp,
                           input int pb_idx, input int pb_exp,
                           input int nwx, input int nwy, input bit ntp);
    int mis1 = 0, mis3 = 0, rd1 = 0, rd3 = 0, bad_addr = 0;
    int de_cnt = 0, hs_cnt = 0, fs_cnt = 0;
    logic [7:0] pa_obs = 'x, pb_obs = 'x;
    logic [10:0] e1, e3;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (i == 500) begin
        win_x = 11'(nwx);
        win_y = 10'(nwy);
        tp_on = ntp;
      end
      e1 = model(i, wx, wy, tp);
      e3 = model((i >= 2) ? i - 2 : i - 2 + FRAME, wx, wy, tp);
      if ({hs1, vs1, de1, data1} !== e1) mis1++;
      if ({hs3, vs3, de3, data3} !== e3) mis3++;
      rd1 += int'(rd_en1);
      rd3 += int'(rd_en3);
      if (!rd_en1 && rd_addr1 != 6'd0) bad_addr++;
      de_cnt += int'(de1);
      hs_cnt += int'(hs1);
      fs_cnt += int'(fs1);
      if (i == pa_idx) pa_obs = data1;
      if (i == pb_idx) pb_obs = data1;
    end
    check({name, "_pix_mis_lat1"}, mis1, 0);
    check({name, "_pix_mis_lat3"}, mis3, 0);
    check({name, "_rd_en_lat1"}, rd1, exp_rd);
    check({name, "_rd_en_lat3"}, rd3, exp_rd);
    check({name, "_addr_idle_zero"}, bad_addr, 0);
    check({name, "_de_count"}, de_cnt, 640);
    check({name, "_hsync_high"}, hs_cnt, 104);
    check({name, "_fs_count"}, fs_cnt, 1);
    check({name, "_fs_at_end"}, fs1, 1'b1);
    check({name, "_probe_a"}, pa_obs, pa_exp);
    check({name, "_probe_b"}, pb_obs, pb_exp);
  endtask

  initial begin
    bit tp_next;
`ifdef TEST_PATTERN_EN
    tp_next = 1'b1;
`else
    tp_next = 1'b0;
`endif
    rst_n = 1'b0;
    win_x = 11'd3;
    win_y = 10'd2;
    tp_on = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs_lat1", {hs1, vs1, de1, rd_en1, rd_addr1, data1, fs1}, 32'd0);
    check("reset_outputs_lat3", {hs3, vs3, de3, rd_en3, rd_addr3, data3, fs3}, 32'd0);

    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("first_frame_start_lat1", fs1, 1'b1);
    check("first_frame_start_lat3", fs3, 1'b1);

    // Window fully inside: row 0 ends at 7, last pixel 31
    run_frame("f1_inside", 3, 2, 1'b0, 32, 6*HT+18, 7, 9*HT+18, 31, 28, 18, 1'b0);
    // Clipped right and bottom: 4 px x 2 lines, row 1 starts at 8, nothing past active
    run_frame("f2_clip", 28, 18, 1'b0, 8, 23*HT+36, 8, 22*HT+40, 0, 0, 0, 1'b0);
    // Origin window; win_x changes to 5 mid-frame
    run_frame("f3_origin", 0, 0, 1'b0, 32, 4*HT+8, 0, 4*HT+16, BG, 5, 0, tp_next);
    // Next frame picks up win_x=5
    run_frame("f4_shift", 5, 0, tp_next, tp_next ? 0 : 32, 4*HT+8, tp_next ? 0 : BG,
              4*HT+13, tp_next ? 8'h24 : 0, 5, 0, 1'b0);

    // Reset mid-line while driving a window pixel (x=7, y=1 -> address 10)
    for (int i = 0; i <= 5*HT+15; i++) @(negedge clk);
    check("pre_reset_pixel", {de1, data1}, {1'b1, 8'd10});
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_lat1", {hs1, vs1, de1, rd_en1, rd_addr1, data1, fs1}, 32'd0);
    check("async_reset_lat3", {hs3, vs3, de3, rd_en3, rd_addr3, data3, fs3}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("restart_frame_start", fs1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
